i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_sync_edge.sv | 33 +++
 rtl/i2c_slave.sv | 198 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file responder.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    IGNORE
  } state_t;

  localparam logic [6:0] I2C_DEF_ADDR = 7'h50;
  localparam int         SYNC_DEPTH   = 2;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one bus line plus rise/fall detection.
module i2c_sync_edge
  import i2c_pkg::*;
#(
  parameter int DEPTH = SYNC_DEPTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;
  logic             prev_q;

  // Flops preset to 1 so an idle bus never looks like an edge after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign level_o = sync_q[DEPTH-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C responder exposing NREG 8-bit registers behind a pointer byte.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the pointer per data byte.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEF_ADDR,
  parameter int         NREG       = 4
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [8*NREG-1:0] reg_flat,
  output logic              wr_pulse,
  output logic              busy
);

  localparam int PW = $clog2(NREG);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [7:0]    shift_q;
  logic          rw_q;
  logic          ack_q;
  logic          sda_oe_q;
  logic          busy_q;
  logic          wr_pulse_q;
  logic [PW-1:0] ptr_q;
  logic [7:0]    regs_q [NREG];

  logic          wr_en;
  logic [7:0]    wr_byte_d;
  logic [PW-1:0] ptr_load_d;
  logic [PW-1:0] ptr_nx_d;

  i2c_sync_edge u_scl (
    .clk_i   (clk_100),
    .rst_i   (rst),
    .d_i     (scl_in),
    .level_o (scl_s),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk_i   (clk_100),
    .rst_i   (rst),
    .d_i     (sda_in),
    .level_o (sda_s),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  // Data byte commits on the 8th SCL rise, independent of a coincident STOP
  assign wr_en      = (state_q == WR) && scl_rise && (cnt_q == 4'd7);
  assign wr_byte_d  = {shift_q[6:0], sda_s};
  assign ptr_load_d = PW'(shift_q % 8'(NREG));

`ifdef I2C_SLAVE_AUTOINC_EN
  logic [PW-1:0] ptr_inc_d;
  assign ptr_inc_d = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_nx_d  = ptr_inc_d;
`else
  assign ptr_nx_d  = ptr_q;
`endif

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
    end else if (stop_det) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      if (wr_en) ptr_q <= ptr_nx_d;
    end else if (start_det) begin
      state_q  <= ADDR;
      cnt_q    <= '0;
      sda_oe_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            shift_q <= {shift_q[6:0], sda_s};
            cnt_q   <= cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_q <= '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              rw_q     <= shift_q[0];
            end else begin
              state_q <= IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_q <= '0;
            if (!rw_q) begin
              state_q  <= PTR;
              sda_oe_q <= 1'b0;
            end else begin
              state_q  <= RD;
              shift_q  <= regs_q[ptr_q];
              sda_oe_q <= ~regs_q[ptr_q][7];
            end
          end
        end
        PTR, WR: begin
          if (scl_rise) begin
            shift_q <= {shift_q[6:0], sda_s};
            cnt_q   <= cnt_q + 4'd1;
            if (wr_en) ptr_q <= ptr_nx_d;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_q    <= '0;
            state_q  <= WR_ACK;
            sda_oe_q <= 1'b1;
            if (state_q == PTR) ptr_q <= ptr_load_d;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_q  <= WR;
            cnt_q    <= '0;
            sda_oe_q <= 1'b0;
          end
        end
        RD: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_q  <= RD_ACK;
              cnt_q    <= '0;
              sda_oe_q <= 1'b0;
            end else begin
              cnt_q    <= cnt_q + 4'd1;
              shift_q  <= {shift_q[6:0], 1'b0};
              sda_oe_q <= ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_q <= sda_s;
          end else if (scl_fall) begin
            cnt_q <= '0;
            if (!ack_q) begin
              state_q  <= RD;
              ptr_q    <= ptr_nx_d;
              shift_q  <= regs_q[ptr_nx_d];
              sda_oe_q <= ~regs_q[ptr_nx_d][7];
            end else begin
              state_q <= IGNORE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      wr_pulse_q <= 1'b0;
    end else begin
      wr_pulse_q <= wr_en;
      if (wr_en) regs_q[ptr_q] <= wr_byte_d;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign reg_flat[8*k +: 8] = regs_q[k];
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench: bit-banged I2C master with an expected-value queue.
// Expectations follow I2C_SLAVE_AUTOINC_EN when it is defined.
module tb_i2c_slave;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic        wr_pulse;
  logic        busy;
  logic [31:0] reg_flat;

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  bit   oe_seen = 1'b0;
  logic [7:0] exp_q [$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave dut (
    .clk_100  (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_flat (reg_flat),
    .wr_pulse (wr_pulse),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // clkdiv: one tick per 8 clocks sets the quarter-bit rate of the master
  logic [2:0] div_q = '0;
  always @(posedge clk) div_q <= div_q + 3'd1;

  always @(posedge clk) begin
    if (wr_pulse) wr_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #600us;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rg(input int k);
    return reg_flat[8*k +: 8];
  endfunction

  task automatic qtr();
    do @(negedge clk); while (div_q != 3'd0);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; qtr();
    sda_m = 1'b0; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b0; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qtr();
    scl_m = 1'b1; qtr();
    sda_m = 1'b1; qtr();
    qtr();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; qtr();
    scl_m = 1'b1; qtr(); qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; qtr();
    scl_m = 1'b1; qtr();
    b = sda_bus; qtr();
    scl_m = 1'b0; qtr();
  endtask

  task automatic wr(input string tag, input logic [7:0] b,
                    input logic exp_ack);
    logic a;
    exp_q.push_back({7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    chk(tag, {31'd0, a}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic rd(input string tag, input logic m_ack,
                    input logic [7:0] exp);
    logic [7:0] d;
    logic       b;
    exp_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(m_ack);
    chk(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
  endtask

  logic       autoinc;
  int         wr0;

  initial begin
`ifdef I2C_SLAVE_AUTOINC_EN
    autoinc = 1'b1;
`else
    autoinc = 1'b0;
`endif
    repeat (4) @(negedge clk);
    chk("rst_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wrp", {31'd0, wr_pulse}, 0);
    chk("rst_regs", reg_flat, 0);
    rst = 1'b0;
    repeat (3) qtr();

    // single data-byte write
    i2c_start();
    wr("w1_addr", 8'hA0, 1'b0);
    chk("w1_busy", {31'd0, busy}, 1);
    wr("w1_ptr", 8'h02, 1'b0);
    wr("w1_data", 8'h5A, 1'b0);
    i2c_stop();
    chk("w1_reg2", {24'd0, rg(2)}, 32'h5A);
    chk("w1_pulses", wr_cnt, 1);
    chk("w1_busy_end", {31'd0, busy}, 0);

    // foreign address is never acknowledged
    oe_seen = 1'b0;
    i2c_start();
    wr("na_addr", 8'hA2, 1'b1);
    chk("na_state", {28'd0, dut.state_q}, {28'd0, IGNORE});
    wr("na_byte", 8'h00, 1'b1);
    chk("na_busy", {31'd0, busy}, 0);
    i2c_stop();
    chk("na_oe_seen", {31'd0, oe_seen}, 0);
    chk("na_idle", {28'd0, dut.state_q}, {28'd0, IDLE});

    // preload reg1/reg2
    i2c_start();
    wr("pl_a", 8'hA0, 1'b0); wr("pl_p", 8'h01, 1'b0);
    wr("pl_d", 8'h11, 1'b0);
    i2c_stop();
    i2c_start();
    wr("pl_a2", 8'hA0, 1'b0); wr("pl_p2", 8'h02, 1'b0);
    wr("pl_d2", 8'h22, 1'b0);
    i2c_stop();
    chk("pl_pulses", wr_cnt, 3);

    // pointer write, repeated START, two-byte read
    i2c_start();
    wr("rd_a", 8'hA0, 1'b0);
    wr("rd_p", 8'h01, 1'b0);
    i2c_rstart();
    wr("rd_ar", 8'hA1, 1'b0);
    rd("rd_b0", 1'b0, 8'h11);
    rd("rd_b1", 1'b1, autoinc ? 8'h22 : 8'h11);
    i2c_stop();

    // pointer persists into a fresh read transaction
    i2c_start();
    wr("pp_a", 8'hA1, 1'b0);
    rd("pp_b", 1'b1, autoinc ? 8'h22 : 8'h11);
    i2c_stop();

    // multi-byte write at the top register
    i2c_start();
    wr("wr_a", 8'hA0, 1'b0); wr("wr_p", 8'h03, 1'b0);
    wr("wr_d0", 8'hAA, 1'b0); wr("wr_d1", 8'hBB, 1'b0);
    i2c_stop();
    chk("wr_reg3", {24'd0, rg(3)}, autoinc ? 32'hAA : 32'hBB);
    chk("wr_reg0", {24'd0, rg(0)}, autoinc ? 32'hBB : 32'h00);
    chk("wr_pulses", wr_cnt, 5);

    // reset while the responder is pulling SDA low during a read
    i2c_start();
    wr("rr_a", 8'hA0, 1'b0); wr("rr_p", 8'h02, 1'b0);
    i2c_rstart();
    wr("rr_ar", 8'hA1, 1'b0);
    chk("rr_drive", {31'd0, sda_oe}, 1);
    rst = 1'b1;
    #1;
    chk("rr_oe", {31'd0, sda_oe}, 0);
    chk("rr_regs", reg_flat, 0);
    chk("rr_busy", {31'd0, busy}, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) qtr();
    i2c_start();
    wr("ra_a", 8'hA0, 1'b0); wr("ra_p", 8'h01, 1'b0);
    wr("ra_d", 8'h77, 1'b0);
    i2c_stop();
    chk("ra_reg1", {24'd0, rg(1)}, 32'h77);
    i2c_start();
    wr("ra_a2", 8'hA0, 1'b0); wr("ra_p2", 8'h01, 1'b0);
    i2c_rstart();
    wr("ra_ar", 8'hA1, 1'b0);
    rd("ra_b", 1'b1, 8'h77);
    i2c_stop();

    // START mid-byte drops the partial byte
    wr0 = wr_cnt;
    i2c_start();
    wr("gs_a", 8'hA0, 1'b0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    i2c_rstart();
    wr("gs_a2", 8'hA0, 1'b0);
    wr("gs_p", 8'h03, 1'b0);
    wr("gs_d", 8'h5C, 1'b0);
    i2c_stop();
    chk("gs_reg3", {24'd0, rg(3)}, 32'h5C);
    chk("gs_pulses", wr_cnt - wr0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
